// File: rtl/sal_ref_ctrl.sv
// sal_ref_ctrl - DDR2 auto-refresh scheduler.
//
// Times the refresh interval (tREFI), accumulates owed refreshes up to
// MAX_POSTPONE (DDR2 postponement) and drives the refresh request/grant
// handshake towards the bank controller. An urgency flag tells the
// request scheduler to stop admitting traffic so the banks can close.
//
// Optional feature (macro SAL_REF_PULLIN_EN): refresh pull-in. While the
// request path is idle, refreshes may be issued early (up to MAX_POSTPONE);
// later interval ticks then retire those credits instead of adding debt.
//
// Parameters:
//   T_REFI_WIDTH   width of the tREFI reload value
//   MAX_POSTPONE   maximum owed refreshes (<= 15, fits ref_pending_o)
//   URGENT_THRESH  owed count at/above which ref_urgent_o asserts
//
// Ports:
//   clk            controller clock
//   rst_n          asynchronous active-low reset
//   ref_en_i       refresh timer enable (set after DRAM init)
//   t_refi_m1_i    tREFI in cycles minus 1, quasi-static
//   idle_i         request path idle (pull-in only; ignored otherwise)
//   ref_req_o      refresh request to the bank controller
//   ref_gnt_i      bank controller issued AUTO-REFRESH this cycle
//   ref_urgent_o   owed count >= URGENT_THRESH
//   ref_pending_o  current owed count
//   ref_ovf_o      sticky: a refresh was lost at saturation
module sal_ref_ctrl #(
  parameter int unsigned T_REFI_WIDTH  = 16,
  parameter int unsigned MAX_POSTPONE  = 8,
  parameter int unsigned URGENT_THRESH = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ref_en_i,
  input  logic [T_REFI_WIDTH-1:0] t_refi_m1_i,
  input  logic                    idle_i,
  output logic                    ref_req_o,
  input  logic                    ref_gnt_i,
  output logic                    ref_urgent_o,
  output logic [3:0]              ref_pending_o,
  output logic                    ref_ovf_o
);

  localparam logic [3:0] MAX_P = 4'(MAX_POSTPONE);
  localparam logic [3:0] URG_T = 4'(URGENT_THRESH);

  logic [T_REFI_WIDTH-1:0] cnt;
  logic                    tick;
  logic                    gnt_acc;
  logic [3:0]              pend, pend_nxt;
  logic                    ovf, ovf_nxt;

  // ---------------------------------------------------------------------
  // Interval counter. While disabled it tracks the reload value so the
  // first tick lands t_refi_m1+1 cycles into the enabled period.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!ref_en_i || (cnt == '0)) begin
      cnt <= t_refi_m1_i;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick    = ref_en_i && (cnt == '0);
  assign gnt_acc = ref_gnt_i && ref_req_o;

`ifdef SAL_REF_PULLIN_EN
  logic [3:0] pull, pull_nxt;
  logic       armed;

  // armed keeps the combinational pull-in term quiet while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // A grant with nothing owed is an early refresh (credit in pull);
  // a tick first consumes a credit before adding debt. A tick and a grant
  // in the same cycle cancel, whichever counter the grant would touch.
  always_comb begin
    pend_nxt = pend;
    ovf_nxt  = ovf;
    pull_nxt = pull;
    if (tick && !gnt_acc) begin
      if (pull != '0) begin
        pull_nxt = pull - 1'b1;
      end else if (pend == MAX_P) begin
        ovf_nxt = 1'b1;
      end else begin
        pend_nxt = pend + 1'b1;
      end
    end else if (gnt_acc && !tick) begin
      if (pend == '0) begin
        pull_nxt = pull + 1'b1;
      end else begin
        pend_nxt = pend - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pull <= '0;
    end else begin
      pull <= pull_nxt;
    end
  end

  // idle_i enters combinationally so a pull-in request drops the same
  // cycle the request path becomes busy.
  assign ref_req_o = (pend != '0) ||
                     (armed && ref_en_i && idle_i && (pull < MAX_P));
`else
  logic unused_idle;
  assign unused_idle = idle_i;

  always_comb begin
    pend_nxt = pend;
    ovf_nxt  = ovf;
    if (tick && !gnt_acc) begin
      if (pend == MAX_P) begin
        ovf_nxt = 1'b1;
      end else begin
        pend_nxt = pend + 1'b1;
      end
    end else if (gnt_acc && !tick) begin
      pend_nxt = pend - 1'b1;
    end
  end

  assign ref_req_o = (pend != '0);
`endif

  // ---------------------------------------------------------------------
  // Owed-refresh counter and sticky overflow.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      ovf  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      ovf  <= ovf_nxt;
    end
  end

  assign ref_urgent_o  = (pend >= URG_T);
  assign ref_pending_o = pend;
  assign ref_ovf_o     = ovf;

endmodule

// File: tb/tb_sal_ref_ctrl.sv
// Testbench for sal_ref_ctrl: directed steps with a cycle model feeding a
// scoreboard queue, plus fixed-value checks at the interesting points.
module tb_sal_ref_ctrl;

  localparam int TW   = 16;
  localparam int MAXP = 8;
  localparam int URG  = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ref_en_i;
  logic [TW-1:0] t_refi_m1_i;
  logic          idle_i;
  logic          ref_req_o;
  logic          ref_gnt_i;
  logic          ref_urgent_o;
  logic [3:0]    ref_pending_o;
  logic          ref_ovf_o;

  always #5 clk = ~clk;

  sal_ref_ctrl #(
    .T_REFI_WIDTH (TW),
    .MAX_POSTPONE (MAXP),
    .URGENT_THRESH(URG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ref_en_i     (ref_en_i),
    .t_refi_m1_i  (t_refi_m1_i),
    .idle_i       (idle_i),
    .ref_req_o    (ref_req_o),
    .ref_gnt_i    (ref_gnt_i),
    .ref_urgent_o (ref_urgent_o),
    .ref_pending_o(ref_pending_o),
    .ref_ovf_o    (ref_ovf_o)
  );

  typedef struct {
    int pend;
    bit ovf;
    int pull;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: phase within the interval, owed and pulled-in.
  int   m_ph, m_pend, m_pull;
  bit   m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit exp_req(input exp_t e);
`ifdef SAL_REF_PULLIN_EN
    return (e.pend != 0) || (ref_en_i && idle_i && (e.pull < MAXP));
`else
    return (e.pend != 0);
`endif
  endfunction

  function automatic exp_t model_now();
    exp_t e;
    e.pend = m_pend;
    e.ovf  = m_ovf;
    e.pull = m_pull;
    return e;
  endfunction

  // One clock cycle: drive inputs, advance the model, push the expected
  // post-edge state, then pop and compare against the DUT after the edge.
  task automatic step(input logic en, input logic gnt, input logic idle);
    bit   tick, gacc;
    exp_t e;
    ref_en_i  = en;
    ref_gnt_i = gnt;
    idle_i    = idle;
    tick = en && (m_ph == int'(t_refi_m1_i));
    gacc = gnt && exp_req(model_now());
    if (!en || tick) m_ph = 0;
    else             m_ph++;
    if (tick && !gacc) begin
      if (m_pull > 0)          m_pull--;
      else if (m_pend == MAXP) m_ovf = 1'b1;
      else                     m_pend++;
    end else if (gacc && !tick) begin
      if (m_pend == 0) m_pull++;
      else             m_pend--;
    end
    sb.push_back(model_now());
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("pend",   32'(ref_pending_o), 32'(e.pend));
      chk("ovf",    32'(ref_ovf_o),     32'(e.ovf));
      chk("urgent", 32'(ref_urgent_o),  32'(e.pend >= URG));
      chk("req",    32'(ref_req_o),     32'(exp_req(e)));
    end
  endtask

  task automatic do_reset();
    ref_en_i  = 1'b0;
    ref_gnt_i = 1'b0;
    idle_i    = 1'b0;
    rst_n     = 1'b0;
    m_ph = 0; m_pend = 0; m_pull = 0; m_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rises[$];
    int   maxp;
    logic prev1, cur;

    // Reset state, checked before any clock edge.
    rst_n       = 1'b0;
    ref_en_i    = 1'b0;
    ref_gnt_i   = 1'b0;
    idle_i      = 1'b0;
    t_refi_m1_i = 16'd99;
    m_ph = 0; m_pend = 0; m_pull = 0; m_ovf = 1'b0;
    #1;
    chk("rst_req",    32'(ref_req_o),     32'd0);
    chk("rst_urgent", 32'(ref_urgent_o),  32'd0);
    chk("rst_pend",   32'(ref_pending_o), 32'd0);
    chk("rst_ovf",    32'(ref_ovf_o),     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Steady refresh with a grant one cycle after each request.
    t_refi_m1_i = 16'd99;
    step(1'b0, 1'b0, 1'b0);
    prev1 = 1'b0;
    cur   = ref_req_o;
    maxp  = 0;
    for (int k = 1; k <= 320; k++) begin
      step(1'b1, prev1, 1'b0);
      prev1 = cur;
      cur   = ref_req_o;
      if (cur && !prev1) rises.push_back(k + 1);
      if (int'(ref_pending_o) > maxp) maxp = int'(ref_pending_o);
    end
    chk("t1_nrise", 32'(rises.size()), 32'd3);
    for (int i = 0; i < rises.size() && i < 3; i++)
      chk("t1_rise_cycle", 32'(rises[i]), 32'(101 + 100 * i));
    chk("t1_maxpend", 32'(maxp), 32'd1);

    // Postponement up to saturation, then overflow and drain.
    do_reset();
    t_refi_m1_i = 16'd9;
    step(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 90; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (k == 50) chk("t2_pend5", 32'(ref_pending_o), 32'd5);
      if (k == 59) chk("t2_urg_lo", 32'(ref_urgent_o), 32'd0);
      if (k == 60) begin
        chk("t2_pend6", 32'(ref_pending_o), 32'd6);
        chk("t2_urg_hi", 32'(ref_urgent_o), 32'd1);
      end
      if (k == 80) chk("t2_pend8", 32'(ref_pending_o), 32'd8);
      if (k == 89) chk("t2_ovf_lo", 32'(ref_ovf_o), 32'd0);
    end
    chk("t2_sat_pend", 32'(ref_pending_o), 32'd8);
    chk("t2_ovf_hi",   32'(ref_ovf_o),     32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("t2_drain", 32'(ref_pending_o), 32'(7 - i));
      if (i == 6) chk("t2_req_last", 32'(ref_req_o), 32'd1);
    end
    chk("t2_req_off", 32'(ref_req_o), 32'd0);
    chk("t2_ovf_sticky", 32'(ref_ovf_o), 32'd1);

    // Tick and grant in the same cycle with three owed.
    do_reset();
    t_refi_m1_i = 16'd9;
    step(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 39; k++) step(1'b1, 1'b0, 1'b0);
    chk("t3_pend3", 32'(ref_pending_o), 32'd3);
    step(1'b1, 1'b1, 1'b0);
    chk("t3_tick_gnt", 32'(ref_pending_o), 32'd3);
    step(1'b1, 1'b1, 1'b0);
    chk("t3_gnt_only", 32'(ref_pending_o), 32'd2);

    // Grant with no request outstanding is ignored.
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
    chk("t4_pend", 32'(ref_pending_o), 32'd0);
    chk("t4_req",  32'(ref_req_o),     32'd0);

`ifdef SAL_REF_PULLIN_EN
    // Pull-in while idle, then the credits absorb the next eight ticks.
    do_reset();
    t_refi_m1_i = 16'd99;
    step(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b1, 1'b1);
    chk("t6_req_full", 32'(ref_req_o), 32'd0);
    rises.delete();
    for (int k = 9; k <= 900; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (ref_req_o) rises.push_back(k + 1);
    end
    chk("t6_nreq", 32'(rises.size()), 32'd1);
    if (rises.size() > 0) chk("t6_first_req", 32'(rises[0]), 32'd901);
    chk("t6_pend", 32'(ref_pending_o), 32'd1);
`endif

    // Asynchronous reset with four owed.
    do_reset();
    t_refi_m1_i = 16'd9;
    step(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 40; k++) step(1'b1, 1'b0, 1'b0);
    chk("t5_pend4", 32'(ref_pending_o), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_req",    32'(ref_req_o),     32'd0);
    chk("t5_urgent", 32'(ref_urgent_o),  32'd0);
    chk("t5_pend",   32'(ref_pending_o), 32'd0);
    chk("t5_ovf",    32'(ref_ovf_o),     32'd0);
    m_ph = 0; m_pend = 0; m_pull = 0; m_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
